writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/wbq_bypass_match.sv | 37 +++
 rtl/writeback_queue.sv | 138 +++++++++++++
 tb/tb_writeback_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: writeback entry layout, queue depth and the $zero address.
// Entry fields are sized to the core XLEN/register-file address width.
package cpu_pkg;

    localparam int CPU_XLEN  = 32;
    localparam int CPU_NADDR = 5;
    localparam int WBQ_DEPTH = 2;

    localparam logic [CPU_NADDR-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 reg_write;
        logic [CPU_NADDR-1:0] dst_addr;
        logic [CPU_XLEN-1:0]  data;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(
        input logic                 reg_write,
        input logic [CPU_NADDR-1:0] dst_addr,
        input logic [CPU_XLEN-1:0]  data
    );
        wb_entry_t e;
        e.reg_write = reg_write;
        e.dst_addr  = dst_addr;
        e.data      = data;
        return e;
    endfunction

endpackage

// File: rtl/wbq_bypass_match.sv
// Compares one read-port address against the queued writeback entries and
// returns the data of the youngest matching entry (0 when nothing matches).
module wbq_bypass_match
    import cpu_pkg::*;
(
    input  wb_entry_t             slot_i [WBQ_DEPTH],
    input  logic [WBQ_DEPTH-1:0]  occupied_i,
    input  logic                  young_sel_i,
    input  logic [CPU_NADDR-1:0]  addr_i,
    output logic                  hit_o,
    output logic [CPU_XLEN-1:0]   data_o
);

    logic [WBQ_DEPTH-1:0] match;
    logic                 old_sel;

    generate
        for (genvar gi = 0; gi < WBQ_DEPTH; gi++) begin : g_cmp
            // $zero is never forwarded, it always reads as 0 in the register file
            assign match[gi] = occupied_i[gi] && slot_i[gi].reg_write &&
                               (slot_i[gi].dst_addr == addr_i) && (addr_i != REG_ZERO);
        end
    endgenerate

    assign old_sel = ~young_sel_i;
    assign hit_o   = |match;

    always_comb begin
        data_o = '0;
        if (match[young_sel_i]) begin
            data_o = slot_i[young_sel_i].data;
        end else if (match[old_sel]) begin
            data_o = slot_i[old_sel].data;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Two-entry in-order writeback FIFO between the memory stage and the register file.
// Optional operand forwarding from queued entries is enabled by WRITEBACK_QUEUE_BYPASS_EN.
module writeback_queue
    import cpu_pkg::*;
#(
    parameter int n     = 32,
    parameter int naddr = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_reg_write,
    input  logic             in_mem_to_reg,
    input  logic [naddr-1:0] in_dst_addr,
    input  logic [n-1:0]     in_alu_result,
    input  logic [n-1:0]     in_mem_data,
    input  logic             stall,
    output logic             wrEn,
    output logic [naddr-1:0] wd_addr,
    output logic [n-1:0]     wd,
    output logic [1:0]       count
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    ,
    input  logic [naddr-1:0] ra_addr,
    input  logic [naddr-1:0] rb_addr,
    output logic             fwd_a_hit,
    output logic             fwd_b_hit,
    output logic [n-1:0]     fwd_a_data,
    output logic [n-1:0]     fwd_b_data
`endif
);

    localparam logic [1:0] FULL_COUNT = 2'(WBQ_DEPTH);

    wb_entry_t  entry_q [WBQ_DEPTH];
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;

    logic       push;
    logic       pop;
    logic       not_empty;
    logic [n-1:0] sel_data;
    wb_entry_t  push_entry;
    wb_entry_t  head;

    assign not_empty = (count_q != 2'd0);
    assign in_ready  = (count_q < FULL_COUNT);
    assign push      = in_valid && in_ready;
    assign pop       = not_empty && !stall;

    // Only the selected result is stored; the unused operand is dropped at enqueue
    assign sel_data   = in_mem_to_reg ? in_mem_data : in_alu_result;
    assign push_entry = make_entry(in_reg_write, CPU_NADDR'(in_dst_addr), CPU_XLEN'(sel_data));
    assign head       = entry_q[rd_ptr_q];

    // Entries being discarded by reset must not reach the register file
    assign wrEn    = pop && !reset && head.reg_write && (head.dst_addr != REG_ZERO);
    assign wd_addr = not_empty ? naddr'(head.dst_addr) : '0;
    assign wd      = not_empty ? n'(head.data) : '0;
    assign count   = count_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: it is only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            entry_q[wr_ptr_q] <= push_entry;
        end
    end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    logic [WBQ_DEPTH-1:0] occupied;
    logic                 young_sel;
    logic [CPU_NADDR-1:0] q_addr [2];
    logic                 q_hit  [2];
    logic [CPU_XLEN-1:0]  q_data [2];

    generate
        for (genvar gi = 0; gi < WBQ_DEPTH; gi++) begin : g_occ
            assign occupied[gi] = (count_q == FULL_COUNT) ||
                                  (not_empty && (rd_ptr_q == 1'(gi)));
        end
    endgenerate

    // With two entries the younger one sits just behind the head
    assign young_sel = (count_q == FULL_COUNT) ? ~rd_ptr_q : rd_ptr_q;
    assign q_addr[0] = CPU_NADDR'(ra_addr);
    assign q_addr[1] = CPU_NADDR'(rb_addr);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            wbq_bypass_match u_match (
                .slot_i      (entry_q),
                .occupied_i  (occupied),
                .young_sel_i (young_sel),
                .addr_i      (q_addr[gi]),
                .hit_o       (q_hit[gi]),
                .data_o      (q_data[gi])
            );
        end
    endgenerate

    assign fwd_a_hit  = q_hit[0];
    assign fwd_b_hit  = q_hit[1];
    assign fwd_a_data = n'(q_data[0]);
    assign fwd_b_data = n'(q_data[1]);
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed vector table, reset and
// bypass sequences, then random traffic against a queue-based reference model.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, stall;
    logic [4:0]  in_dst_addr;
    logic [31:0] in_alu_result, in_mem_data;
    logic        wrEn;
    logic [4:0]  wd_addr;
    logic [31:0] wd;
    logic [1:0]  count;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    logic [4:0]  ra_addr, rb_addr;
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_a_data, fwd_b_data;
`endif

    always #5 clk = ~clk;

    writeback_queue #(.n(32), .naddr(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_dst_addr   (in_dst_addr),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .stall         (stall),
        .wrEn          (wrEn),
        .wd_addr       (wd_addr),
        .wd            (wd),
        .count         (count)
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        ,
        .ra_addr       (ra_addr),
        .rb_addr       (rb_addr),
        .fwd_a_hit     (fwd_a_hit),
        .fwd_b_hit     (fwd_b_hit),
        .fwd_a_data    (fwd_a_data),
        .fwd_b_data    (fwd_b_data)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic st,
                         input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] mem);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        stall         = st;
        in_dst_addr   = dst;
        in_alu_result = alu;
        in_mem_data   = mem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected before that edge
    typedef struct {
        logic        v, rw, m2r, st;
        logic [4:0]  dst;
        logic [31:0] alu, mem;
        logic [1:0]  e_count;
        logic        e_ready, e_wren;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
    } vec_t;

    function automatic vec_t mk(input logic v, rw, m2r, st, input logic [4:0] dst,
                                input logic [31:0] alu, mem, input logic [1:0] ec,
                                input logic er, ew, input logic [4:0] ea, input logic [31:0] ed);
        vec_t t;
        t.v = v; t.rw = rw; t.m2r = m2r; t.st = st; t.dst = dst; t.alu = alu; t.mem = mem;
        t.e_count = ec; t.e_ready = er; t.e_wren = ew; t.e_addr = ea; t.e_wd = ed;
        return t;
    endfunction

    // Reference model: the queue contents as a plain list, head at index 0
    typedef struct {
        logic        rw;
        logic [4:0]  dst;
        logic [31:0] data;
    } ment_t;
    ment_t mq[$];

    task automatic model_check(input string tag);
        logic        e_wren;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        e_wren = !reset && (mq.size() > 0) && !stall && mq[0].rw && (mq[0].dst != 5'd0);
        e_addr = (mq.size() > 0) ? mq[0].dst : 5'd0;
        e_wd   = (mq.size() > 0) ? mq[0].data : 32'd0;
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        chk({tag, "_wren"}, 32'(wrEn), 32'(e_wren));
        chk({tag, "_addr"}, 32'(wd_addr), 32'(e_addr));
        chk({tag, "_wd"}, wd, e_wd);
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        begin
            logic hit_a, hit_b;
            logic [31:0] dat_a, dat_b;
            hit_a = 1'b0; hit_b = 1'b0; dat_a = '0; dat_b = '0;
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].rw && mq[i].dst == ra_addr && ra_addr != 5'd0) begin
                    hit_a = 1'b1; dat_a = mq[i].data;
                end
                if (mq[i].rw && mq[i].dst == rb_addr && rb_addr != 5'd0) begin
                    hit_b = 1'b1; dat_b = mq[i].data;
                end
            end
            chk({tag, "_fwd_a_hit"}, 32'(fwd_a_hit), 32'(hit_a));
            chk({tag, "_fwd_a_data"}, fwd_a_data, dat_a);
            chk({tag, "_fwd_b_hit"}, 32'(fwd_b_hit), 32'(hit_b));
            chk({tag, "_fwd_b_data"}, fwd_b_data, dat_b);
        end
`endif
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        ment_t e;
        if (reset) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() > 0) && !stall;
            do_push = in_valid && (mq.size() < 2);
            e.rw    = in_reg_write;
            e.dst   = in_dst_addr;
            e.data  = in_mem_to_reg ? in_mem_data : in_alu_result;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
`ifdef WRITEBACK_QUEUE_BYPASS_EN
        ra_addr = 5'd0;
        rb_addr = 5'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_wren", 32'(wrEn), 32'd0);
        chk("reset_addr", 32'(wd_addr), 32'd0);
        chk("reset_wd", wd, 32'd0);
        chk("reset_ready", 32'(in_ready), 32'd1);

        //        v rw m2r st dst  alu           mem           cnt rdy wen addr wd
        vecs.push_back(mk(1, 1, 0, 0, 5,  32'hDEADBEEF, 32'h0,        0, 1, 0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 1, 1, 5,  32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 1, 0, 9,  32'h1,        32'h12345678, 0, 1, 0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 1, 1, 9,  32'h12345678));
        vecs.push_back(mk(1, 1, 0, 1, 3,  32'h33,       32'h0,        0, 1, 0, 0,  32'h0));
        vecs.push_back(mk(1, 1, 0, 1, 4,  32'h44,       32'h0,        1, 1, 0, 3,  32'h33));
        vecs.push_back(mk(1, 1, 0, 1, 6,  32'h66,       32'h0,        2, 0, 0, 3,  32'h33));
        vecs.push_back(mk(1, 1, 0, 0, 6,  32'h66,       32'h0,        2, 0, 1, 3,  32'h33));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 1, 1, 4,  32'h44));
        vecs.push_back(mk(1, 1, 0, 0, 0,  32'hFFFFFFFF, 32'h0,        0, 1, 0, 0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 1, 0, 0,  32'hFFFFFFFF));
        vecs.push_back(mk(1, 1, 0, 0, 2,  32'h22,       32'h0,        0, 1, 0, 0,  32'h0));
        vecs.push_back(mk(1, 1, 0, 0, 8,  32'h88,       32'h0,        1, 1, 1, 2,  32'h22));
        vecs.push_back(mk(1, 0, 0, 0, 10, 32'hAA,       32'h0,        1, 1, 1, 8,  32'h88));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        1, 1, 0, 10, 32'hAA));
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 1, 0, 0,  32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].st,
                  vecs[i].dst, vecs[i].alu, vecs[i].mem);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_wren", i), 32'(wrEn), 32'(vecs[i].e_wren));
            chk($sformatf("vec%0d_addr", i), 32'(wd_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_wd", i), wd, vecs[i].e_wd);
            $display("vec %0d: v=%0b st=%0b dst=%0d -> count=%0d wrEn=%0b wd_addr=%0d wd=0x%08h",
                     i, vecs[i].v, vecs[i].st, vecs[i].dst, count, wrEn, wd_addr, wd);
            tick();
        end

        // Reset with a full queue: nothing may be written, in the reset cycle or after
        drive(1, 1, 0, 1, 5'd11, 32'h111, 32'h0);
        tick();
        drive(1, 1, 0, 1, 5'd12, 32'h222, 32'h0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("full_before_reset_count", 32'(count), 32'd2);
        reset = 1'b1;
        #1;
        chk("reset_cycle_wren", 32'(wrEn), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_count", 32'(count), 32'd0);
        chk("post_reset_wren", 32'(wrEn), 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("discard%0d_wren", i), 32'(wrEn), 32'd0);
            $display("discard %0d: count=%0d wrEn=%0b", i, count, wrEn);
            tick();
        end

`ifdef WRITEBACK_QUEUE_BYPASS_EN
        // Two entries for the same register: the younger one must be forwarded
        drive(1, 1, 0, 1, 5'd7, 32'hA, 32'h0);
        tick();
        drive(1, 1, 0, 1, 5'd7, 32'hB, 32'h0);
        tick();
        drive(0, 0, 0, 1, 5'd0, 32'h0, 32'h0);
        ra_addr = 5'd7;
        rb_addr = 5'd7;
        #1;
        chk("byp_a_hit", 32'(fwd_a_hit), 32'd1);
        chk("byp_a_data", fwd_a_data, 32'hB);
        chk("byp_b_data", fwd_b_data, 32'hB);
        ra_addr = 5'd0;
        #1;
        chk("byp_zero_hit", 32'(fwd_a_hit), 32'd0);
        chk("byp_zero_data", fwd_a_data, 32'd0);
        $display("bypass: ra=7 -> 0x%08h, ra=0 -> hit=%0b", fwd_b_data, fwd_a_hit);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        // Random traffic against the reference model
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom, $urandom);
`ifdef WRITEBACK_QUEUE_BYPASS_EN
            ra_addr = 5'($urandom_range(0, 7));
            rb_addr = 5'($urandom_range(0, 7));
`endif
            #1;
            model_check($sformatf("rnd%0d", c));
            $display("rnd %0d: rst=%0b v=%0b st=%0b dst=%0d count=%0d wrEn=%0b wd_addr=%0d wd=0x%08h",
                     c, reset, in_valid, stall, in_dst_addr, count, wrEn, wd_addr, wd);
            @(posedge clk);
            model_step();
            #1;
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
